break_arbiter: RTL

Data-break (DMA) arbiter and sequencer for the PDP-8/e memory path. It accepts single-word break requests from up to NREQ peripherals and picks one winner. The winner gets one memory cycle, inserted at a CPU major-state boundary: the CPU state machine is held in F0/D0/E0 while the break cycle owns the memory address/data path. It sits between the peripheral break ports, the CPU state machine (via `brk_hold`) and the memory address/data multiplexer.

---
 rtl/break_arbiter_pkg.sv | 14 +
 rtl/break_priority.sv | 22 ++
 rtl/break_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/break_arbiter_pkg.sv
// break_arbiter_pkg: break-cycle state encodings, requester count default and index width helper
package break_arbiter_pkg;
    localparam int NREQ_DEF = 4;
    typedef enum logic [2:0] {
        BI = 3'd0,
        B0 = 3'd1,
        B1 = 3'd2,
        B2 = 3'd3,
        B3 = 3'd4
    } bstate_t;
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/break_priority.sv
// break_priority: picks the first requesting index at or after start, wrapping to the lowest index
module break_priority
    import break_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    localparam int IW = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   start,
    output logic            valid,
    output logic [IW-1:0]   idx
);
    always_comb begin
        valid = |req;
        idx = '0;
        // wrapped candidates first, so any candidate at or above start overrides them
        for (int j = NREQ - 1; j >= 0; j--)
            if (req[j] && j < int'(start)) idx = IW'(j);
        for (int j = NREQ - 1; j >= 0; j--)
            if (req[j] && j >= int'(start)) idx = IW'(j);
    end
endmodule

// File: rtl/break_arbiter.sv
// break_arbiter: PDP-8/e data-break arbiter, one four-cycle memory break per CPU major-state boundary.
// Define BREAK_RR_EN for round-robin arbitration; otherwise requester 0 has fixed highest priority.
module break_arbiter
    import break_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_boundary,
    input  logic              cpu_halted,
    input  logic [NREQ-1:0]   brk_req,
    input  logic [NREQ-1:0]   brk_we,
    input  logic [NREQ*15-1:0] brk_addr,
    input  logic [NREQ*12-1:0] brk_wdata,
    input  logic [0:11]       mem_rdata,
    output logic              brk_hold,
    output logic              mem_sel,
    output logic [0:14]       mem_addr,
    output logic [0:11]       mem_wdata,
    output logic              mem_we,
    output logic [NREQ-1:0]   brk_ack,
    output logic [0:11]       brk_rdata
);
    localparam int IW = idx_w(NREQ);

    bstate_t state_q, state_d;
    logic [IW-1:0] win_q, win_d, ptr, grant_idx;
    logic grant_ok, grant;
    logic we_q, we_d, hold_q, hold_d, mwe_q, mwe_d;
    logic [14:0] addr_q, addr_d;
    logic [11:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [NREQ-1:0] ack_q, ack_d;

`ifdef BREAK_RR_EN
    logic [IW-1:0] ptr_q, ptr_d;
    assign ptr = ptr_q;
    always_comb ptr_d = grant ? (grant_idx == IW'(NREQ - 1) ? '0 : grant_idx + 1'b1) : ptr_q;
    always_ff @(posedge clk) ptr_q <= reset ? '0 : ptr_d;
`else
    assign ptr = '0;
`endif

    break_priority #(.NREQ(NREQ)) u_prio (
        .req  (brk_req),
        .start(ptr),
        .valid(grant_ok),
        .idx  (grant_idx)
    );

    assign grant = state_q == BI && grant_ok && (cpu_boundary || cpu_halted);

    always_comb begin
        state_d = state_q == BI ? (grant ? B0 : BI) :
                  state_q == B0 ? B1 :
                  state_q == B1 ? B2 :
                  state_q == B2 ? B3 : BI;
        win_d   = grant ? grant_idx : win_q;
        addr_d  = grant ? brk_addr[int'(grant_idx)*15 +: 15] : addr_q;
        we_d    = grant ? brk_we[grant_idx] : we_q;
        wdata_d = grant ? brk_wdata[int'(grant_idx)*12 +: 12] : wdata_q;
        rdata_d = state_q == B2 ? mem_rdata : rdata_q;
        // outputs are registered, so they are decoded from the state being entered
        hold_d  = state_d != BI;
        mwe_d   = state_d == B2 && we_q;
        ack_d   = state_d == B3 ? NREQ'(1) << win_q : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BI;
            win_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            hold_q  <= 1'b0;
            mwe_q   <= 1'b0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            hold_q  <= hold_d;
            mwe_q   <= mwe_d;
            ack_q   <= ack_d;
        end
    end

    assign brk_hold  = hold_q;
    assign mem_sel   = hold_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = mwe_q;
    assign brk_ack   = ack_q;
    assign brk_rdata = rdata_q;
endmodule
